// File: rtl/cle_pack.sv
// -----------------------------------------------------------------------------
// cle_pack -- read-back engine for the CLE label map.
//
// Once labelling has finished, a start pulse makes this block walk the label
// SRAM in address order. It turns every label into a one-bit object/background
// pixel, packs eight pixels per byte (leftmost pixel in the MSB, the same
// layout as the input bitmap ROM), and writes each byte to the packed-image
// memory. While scanning it also counts how many distinct nonzero labels
// appear, which gives the hardware object count.
//
// Ports
//   clk       single clock, all state changes on its rising edge
//   reset     asynchronous, active-high reset
//   test_se   scan enable, no functional effect
//   start     begin a scan, sampled only while idle
//   sram_a    label SRAM read address
//   sram_q    label SRAM read data, valid the cycle after its address
//   sram_wen  label SRAM write enable (active-low), tied inactive
//   pk_a      packed-memory write address
//   pk_d      packed-memory write data
//   pk_wen    packed-memory write enable (active-low), one cycle per byte
//   obj_cnt   number of distinct nonzero labels in the scanned map
//   busy      high while a scan is in progress
//   finish    scan complete, held until the next accepted start
//
// Timing (E0 = edge that accepts start)
//   sram_a = i after edge E0+i, up to NPIX-1 where it holds.
//   The SRAM registers address i at E0+i+1; its label is sampled at E0+i+2.
//   Pixel 8k+7 is sampled at E0+8k+9, and that same edge writes byte k.
//   The last byte is written at E0+NPIX+1 and finish rises at E0+NPIX+2.
// -----------------------------------------------------------------------------
module cle_pack #(
   parameter int NPIX = 1024,  // pixels scanned, multiple of 8
   parameter int AW   = 10,    // SRAM address width, 2**AW >= NPIX
   parameter int PAW  = 7      // packed-memory address width, 2**PAW >= NPIX/8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           test_se,
   input  logic           start,
   output logic [AW-1:0]  sram_a,
   input  logic [7:0]     sram_q,
   output logic           sram_wen,
   output logic [PAW-1:0] pk_a,
   output logic [7:0]     pk_d,
   output logic           pk_wen,
   output logic [7:0]     obj_cnt,
   output logic           busy,
   output logic           finish
);

   // --------------------------------------------------------------------------
   // Controller states
   // --------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE  = 2'd0;  // waiting for start
   localparam logic [1:0] S_READ  = 2'd1;  // issuing SRAM addresses
   localparam logic [1:0] S_DRAIN = 2'd2;  // last labels still in flight
   localparam logic [1:0] S_DONE  = 2'd3;  // last byte written, raise finish

   localparam logic [AW-1:0]  LAST_ADDR = AW'(NPIX - 1);
   localparam logic [PAW-1:0] LAST_BYTE = PAW'(NPIX / 8 - 1);

   logic [1:0]     state;

   // Two-stage valid pipeline that follows the synchronous SRAM read:
   // addr_v marks a fresh address on sram_a, data_v marks sram_q holding the
   // label for that address one cycle later.
   logic           addr_v;
   logic           data_v;

   // Packing state: bit_cnt is the position of the next pixel within its
   // byte, byte_cnt the byte it belongs to, shift the earlier pixels of the
   // byte being assembled (oldest in the MSB).
   logic [2:0]     bit_cnt;
   logic [PAW-1:0] byte_cnt;
   logic [6:0]     shift;

   // One flag per possible label value; flag 0 is never set.
   logic [255:0]   seen;

   // Decoded per-cycle conditions
   logic           start_ok;
   logic           pix;
   logic           byte_done;
   logic           last_byte;
   logic           new_label;

   // The block only reads the label SRAM.
   assign sram_wen = 1'b1;

   // Scan enable is consumed by DFT insertion only.
   logic unused_test_se;
   assign unused_test_se = test_se;

   // --------------------------------------------------------------------------
   // Decode
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a value before any
      // condition is tested, so no path can leave it unassigned and imply a latch.
      start_ok  = 1'b0;
      pix       = 1'b0;
      byte_done = 1'b0;
      last_byte = 1'b0;
      new_label = 1'b0;

      start_ok = (state == S_IDLE) && start;

      if (data_v) begin
         pix       = (sram_q != 8'd0);
         byte_done = (bit_cnt == 3'd7);
         last_byte = byte_done && (byte_cnt == LAST_BYTE);
         new_label = pix && !seen[sram_q];
      end
   end

   // --------------------------------------------------------------------------
   // Controller and SRAM address generator
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         sram_a <= '0;
         addr_v <= 1'b0;
         data_v <= 1'b0;
         busy   <= 1'b0;
         finish <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // register in the block sees the values from before the clock edge.
         data_v <= addr_v;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_READ;
                  sram_a <= '0;
                  addr_v <= 1'b1;
                  busy   <= 1'b1;
                  finish <= 1'b0;
               end
            end

            S_READ: begin
               // The final address stays on the bus; only the valid flag drops.
               if (sram_a == LAST_ADDR) begin
                  addr_v <= 1'b0;
                  state  <= S_DRAIN;
               end else begin
                  sram_a <= sram_a + 1'b1;
               end
            end

            S_DRAIN: begin
               if (last_byte) begin
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               finish <= 1'b1;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Pixel packing and packed-memory write port
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         byte_cnt <= '0;
         shift    <= '0;
         pk_a     <= '0;
         pk_d     <= '0;
         pk_wen   <= 1'b1;
      end else begin
         // Write strobe is a single-cycle pulse unless the next byte
         // completes on the following edge.
         pk_wen <= 1'b1;

         if (start_ok) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
         end else if (data_v) begin
            bit_cnt <= bit_cnt + 3'd1;
            // Stale bits left in shift after a byte completes are pushed out
            // by the next seven pixels before they are ever used.
            shift   <= {shift[5:0], pix};
            if (byte_done) begin
               pk_a     <= byte_cnt;
               pk_d     <= {shift, pix};
               pk_wen   <= 1'b0;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Distinct-label counter
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the seen table is a flop array, not an SRAM, so it can be
         // cleared by reset in one cycle; it is also cleared on every start.
         seen    <= '0;
         obj_cnt <= '0;
      end else if (start_ok) begin
         seen    <= '0;
         obj_cnt <= '0;
      end else if (new_label) begin
         // At most 255 distinct nonzero labels exist, so 8 bits never wrap.
         seen[sram_q] <= 1'b1;
         obj_cnt      <= obj_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_cle_pack.sv
// -----------------------------------------------------------------------------
// tb_cle_pack -- self-checking bench for cle_pack.
//
// A behavioural label SRAM feeds the DUT and a monitor logs every packed-memory
// write. Expected bytes and object counts come from a reference model that
// works directly on the label array (pixel = label != 0, distinct labels
// collected in an associative array). Table rows select a fill pattern, an
// optional start pulse during the scan, and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_cle_pack;

   localparam int NPIX   = 1024;
   localparam int AW     = 10;
   localparam int PAW    = 7;
   localparam int NBYTES = NPIX / 8;
   localparam int LAT    = NPIX + 2;   // start edge to finish edge

   logic           clk = 1'b0;
   logic           reset;
   logic           test_se;
   logic           start;
   logic [AW-1:0]  sram_a;
   logic [7:0]     sram_q;
   logic           sram_wen;
   logic [PAW-1:0] pk_a;
   logic [7:0]     pk_d;
   logic           pk_wen;
   logic [7:0]     obj_cnt;
   logic           busy;
   logic           finish;

   cle_pack #(.NPIX(NPIX), .AW(AW), .PAW(PAW)) dut (
      .clk      (clk),
      .reset    (reset),
      .test_se  (test_se),
      .start    (start),
      .sram_a   (sram_a),
      .sram_q   (sram_q),
      .sram_wen (sram_wen),
      .pk_a     (pk_a),
      .pk_d     (pk_d),
      .pk_wen   (pk_wen),
      .obj_cnt  (obj_cnt),
      .busy     (busy),
      .finish   (finish)
   );

   always #5 clk = ~clk;

   // Label SRAM with a registered read port
   logic [7:0] mem [NPIX];
   always @(posedge clk) sram_q <= mem[sram_a];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Packed-memory write log, sampled on the falling edge
   typedef struct {int a; int d; int t;} wr_t;
   wr_t wlog[$];
   int  bad_wen = 0;

   always @(negedge clk) begin
      if (sram_wen !== 1'b1) bad_wen <= bad_wen + 1;
      if (pk_wen === 1'b0) wlog.push_back('{int'(pk_a), int'(pk_d), cyc});
   end

   // Reference model results
   logic [7:0] exp_b [NBYTES];
   int         exp_obj;
   logic [7:0] got_b [NBYTES];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef enum {P_ZERO, P_ONE, P_THREE, P_RAMP, P_SPARSE, P_FULL} pat_e;

   task automatic fill(input pat_e p);
      for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
      case (p)
         P_ONE:   mem[0] = 8'h01;
         P_THREE: begin
            mem[7]    = 8'h05;
            mem[8]    = 8'h03;
            mem[1023] = 8'h05;
         end
         P_RAMP:   for (int i = 0; i < 255; i++) mem[i] = 8'(i + 1);
         P_SPARSE: for (int i = 0; i < NPIX; i++)
                      if ($urandom_range(0, 3) == 0) mem[i] = 8'($urandom_range(1, 40));
         P_FULL:   for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
         default: ;
      endcase
   endtask

   function automatic void build_model();
      int uniq[int];
      for (int k = 0; k < NBYTES; k++) begin
         int b = 0;
         for (int j = 0; j < 8; j++)
            if (mem[8*k + j] != 8'h00) b += (1 << (7 - j));
         exp_b[k] = 8'(b);
      end
      for (int i = 0; i < NPIX; i++)
         if (mem[i] != 8'h00) uniq[int'(mem[i])] = 1;
      exp_obj = uniq.num();
   endfunction

   // One complete scan, optionally with a start pulse pulse_at cycles in.
   task automatic run_scan(input string tag, input int pulse_at);
      int n0, base, nw;
      for (int i = 0; i < NBYTES; i++) got_b[i] = 8'hxx;
      base = wlog.size();
      @(negedge clk);
      start = 1'b1;
      n0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ":finish_cleared"}, finish, 1'b0);
      check({tag, ":busy"}, busy, 1'b1);
      check({tag, ":obj_cleared"}, obj_cnt, 8'd0);
      while (finish !== 1'b1 && (cyc - n0) < LAT + 80) begin
         @(negedge clk);
         start = ((cyc - n0) == pulse_at);
      end
      start = 1'b0;
      check({tag, ":finish_latency"}, cyc - n0, LAT);
      check({tag, ":busy_low"}, busy, 1'b0);
      check({tag, ":obj_cnt"}, obj_cnt, exp_obj);
      nw = wlog.size() - base;
      check({tag, ":n_writes"}, nw, NBYTES);
      for (int i = 0; i < nw && i < NBYTES; i++) begin
         got_b[i] = 8'(wlog[base + i].d);
         check($sformatf("%s:addr%0d", tag, i), wlog[base + i].a, i);
         check($sformatf("%s:data%0d", tag, i), wlog[base + i].d, exp_b[i]);
         check($sformatf("%s:time%0d", tag, i), wlog[base + i].t - n0, 9 + 8 * i);
      end
      repeat (3) @(negedge clk);
      check({tag, ":finish_held"}, finish, 1'b1);
      check({tag, ":obj_held"}, obj_cnt, exp_obj);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ":sram_a"}, sram_a, '0);
      check({tag, ":pk_a"}, pk_a, '0);
      check({tag, ":pk_d"}, pk_d, 8'h00);
      check({tag, ":pk_wen"}, pk_wen, 1'b1);
      check({tag, ":obj_cnt"}, obj_cnt, 8'd0);
      check({tag, ":busy"}, busy, 1'b0);
      check({tag, ":finish"}, finish, 1'b0);
   endtask

   typedef struct {
      pat_e  pat;
      int    pulse_at;  // -1 = no disturbing start pulse
      int    obj;       // -1 = model only
      int    b0;
      int    b1;
      int    xi;        // extra byte index to pin down
      int    xb;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{P_ZERO,   -1,   0, 8'h00, 8'h00, 127, 8'h00};
      vecs[1] = '{P_ONE,    -1,   1, 8'h80, 8'h00, 127, 8'h00};
      vecs[2] = '{P_THREE,  -1,   2, 8'h01, 8'h80, 127, 8'h01};
      vecs[3] = '{P_RAMP,   -1, 255, 8'hFF, 8'hFF,  31, 8'hFE};
      vecs[4] = '{P_THREE, 300,   2, 8'h01, 8'h80, 127, 8'h01};
      vecs[5] = '{P_SPARSE, -1,  -1, -1,    -1,     -1, -1};
      vecs[6] = '{P_FULL,   -1,  -1, -1,    -1,     -1, -1};
      vecs[7] = '{P_SPARSE, 500, -1, -1,    -1,     -1, -1};

      reset   = 1'b1;
      start   = 1'b0;
      test_se = 1'b0;
      fill(P_ZERO);
      repeat (3) @(negedge clk);
      check_reset_values("in_reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("idle");

      for (int v = 0; v < 8; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         fill(vecs[v].pat);
         build_model();
         run_scan(tag, vecs[v].pulse_at);
         if (vecs[v].obj >= 0) begin
            check({tag, ":tbl_obj"}, obj_cnt, vecs[v].obj);
            check({tag, ":tbl_b0"}, got_b[0], vecs[v].b0);
            check({tag, ":tbl_b1"}, got_b[1], vecs[v].b1);
            check({tag, ":tbl_bx"}, got_b[vecs[v].xi], vecs[v].xb);
         end
      end

      // Reset in the middle of a scan
      begin
         int n0, base;
         fill(P_SPARSE);
         build_model();
         @(negedge clk);
         start = 1'b1;
         n0 = cyc + 1;
         @(negedge clk);
         start = 1'b0;
         while ((cyc - n0) < 500) @(negedge clk);
         reset = 1'b1;
         #1;
         check_reset_values("abort");
         base = wlog.size();
         @(negedge clk);
         reset = 1'b0;
         repeat (40) @(negedge clk);
         check("abort:no_writes", wlog.size() - base, 0);
         check("abort:finish_low", finish, 1'b0);
         check("abort:busy_low", busy, 1'b0);
         check("abort:pk_wen", pk_wen, 1'b1);
         run_scan("after_abort", -1);
      end

      // Back-to-back scans: second start accepted while finish is high
      fill(P_FULL);
      build_model();
      run_scan("b2b_1", -1);
      check("b2b:finish_before", finish, 1'b1);
      fill(P_SPARSE);
      build_model();
      run_scan("b2b_2", -1);

      @(negedge clk);
      check("sram_wen_never_low", bad_wen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
